// File: rtl/note_sequencer.sv
// Melody sequencer: a DEPTH-entry FIFO of {rest, note, beats} entries, played back
// one entry at a time as registered tone index + mute to a downstream tone generator.
// Latency: an accepted start loads the head entry on that edge; each entry lasts beats*BEAT_CYCLES cycles.
// Backpressure: in_ready = (level < DEPTH); writes are accepted while playing; stop wins over start.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_rest/in_note/in_beats melody write;
//        start/stop level-sampled controls; note/hush registered tone outputs; busy/done status;
//        level FIFO occupancy.
// Optional feature: define NOTE_SEQ_GAP_EN to insert a GAP_CYCLES silent gap between entries.
module note_sequencer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned BEAT_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_rest,
    input  logic [3:0]               in_note,
    input  logic [3:0]               in_beats,
    input  logic                     start,
    input  logic                     stop,
    output logic [3:0]               note,
    output logic                     hush,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = $clog2(BEAT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1
`ifdef NOTE_SEQ_GAP_EN
        ,
        S_GAP  = 2'd2
`endif
    } state_t;

    // Zero-length gaps are not a supported configuration; this empty block only
    // exists so a bad GAP_CYCLES shows up by name in the elaborated hierarchy.
    if (GAP_CYCLES == 0) begin : g_gap_cycles_zero_unsupported
    end

    state_t          state_q, state_d;
    logic [3:0]      note_q, note_d;
    logic            hush_q, hush_d;
    logic            done_q, done_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [4:0]      beats_q, beats_d;   // remaining beats, 1..16
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [8:0]      mem_q [DEPTH];

`ifdef NOTE_SEQ_GAP_EN
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0]   gap_q, gap_d;
`endif

    logic [8:0]      head;
    logic            push, pop, load;
    logic            have_next, beat_wrap, entry_end;

    assign head      = mem_q[rd_ptr_q];
    assign in_ready  = (level_q < LW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign have_next = (level_q != '0);
    assign beat_wrap = (pre_q == PW'(BEAT_CYCLES - 1));
    assign entry_end = beat_wrap && (beats_q == 5'd1);

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        hush_d  = hush_q;
        done_d  = 1'b0;
        pre_d   = pre_q;
        beats_d = beats_q;
        load    = 1'b0;
        pop     = 1'b0;
`ifdef NOTE_SEQ_GAP_EN
        gap_d   = gap_q;
`endif
        if (stop) begin
            state_d = S_IDLE;
            hush_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && have_next) begin
                        load = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (beat_wrap) begin
                        pre_d   = '0;
                        beats_d = beats_q - 5'd1;
                    end else begin
                        pre_d   = pre_q + PW'(1);
                    end
                    if (entry_end) begin
                        if (have_next) begin
`ifdef NOTE_SEQ_GAP_EN
                            state_d = S_GAP;
                            hush_d  = 1'b1;
                            gap_d   = '0;
`else
                            load    = 1'b1;
`endif
                        end else begin
                            state_d = S_IDLE;
                            hush_d  = 1'b1;
                            done_d  = 1'b1;
                        end
                    end
                end
`ifdef NOTE_SEQ_GAP_EN
                S_GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        // Occupancy is re-checked here: the queue may only be
                        // judged at the moment the next entry would load.
                        if (have_next) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            hush_d  = 1'b1;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    hush_d  = 1'b1;
                end
            endcase
        end

        // A load overrides the counter updates above; beats==0 means 16.
        if (load) begin
            pop     = 1'b1;
            state_d = S_PLAY;
            note_d  = head[7:4];
            hush_d  = head[8];
            pre_d   = '0;
            beats_d = (head[3:0] == 4'd0) ? 5'd16 : {1'b0, head[3:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            note_q   <= 4'd0;
            hush_q   <= 1'b1;
            done_q   <= 1'b0;
            pre_q    <= '0;
            beats_q  <= 5'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            hush_q   <= hush_d;
            done_q   <= done_d;
            pre_q    <= pre_d;
            beats_q  <= beats_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef NOTE_SEQ_GAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gap_q <= '0;
        else        gap_q <= gap_d;
    end
`endif

    // Storage needs no reset: it is only read behind a nonzero level.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_rest, in_note, in_beats};
    end

    assign note  = note_q;
    assign hush  = hush_q;
    assign done  = done_q;
    assign busy  = (state_q != S_IDLE);
    assign level = level_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with BEAT_CYCLES=4, GAP_CYCLES=2, DEPTH=8.
// A queue-based model tracks remaining cycles per entry and is compared every cycle;
// directed scenarios add literal expectations on note/hush/busy/done/level.
module tb_note_sequencer;

    localparam int DEPTH = 8;
    localparam int BEAT  = 4;
    localparam int GAP   = 2;

    logic       clk, rst_n;
    logic       in_valid, in_ready, in_rest;
    logic [3:0] in_note, in_beats;
    logic       start, stop;
    logic [3:0] note;
    logic       hush, busy, done;
    logic [3:0] level;

    int checks = 0;
    int errors = 0;

    note_sequencer #(.DEPTH(DEPTH), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rest(in_rest),
        .in_note(in_note), .in_beats(in_beats),
        .start(start), .stop(stop),
        .note(note), .hush(hush), .busy(busy), .done(done), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [8:0] mq[$];
    logic       m_busy, m_gap, m_hush, m_done;
    logic [3:0] m_note;
    int         m_left;

    task automatic m_load();
        logic [8:0] e;
        e      = mq.pop_front();
        m_note = e[7:4];
        m_hush = e[8];
        m_left = ((e[3:0] == 4'd0) ? 16 : int'(e[3:0])) * BEAT;
        m_busy = 1'b1;
        m_gap  = 1'b0;
    endtask

    task automatic m_finish();
        m_busy = 1'b0;
        m_gap  = 1'b0;
        m_hush = 1'b1;
        m_done = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_busy = 1'b0; m_gap = 1'b0; m_hush = 1'b1; m_done = 1'b0;
            m_note = 4'd0; m_left = 0;
        end else begin
            bit acc;
            acc    = in_valid && (mq.size() < DEPTH);
            m_done = 1'b0;
            if (stop) begin
                m_busy = 1'b0; m_gap = 1'b0; m_hush = 1'b1;
            end else if (!m_busy) begin
                if (start && mq.size() > 0) m_load();
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_gap) begin
                        if (mq.size() > 0) m_load();
                        else m_finish();
                    end else if (mq.size() > 0) begin
`ifdef NOTE_SEQ_GAP_EN
                        m_gap = 1'b1; m_left = GAP; m_hush = 1'b1;
`else
                        m_load();
`endif
                    end else begin
                        m_finish();
                    end
                end
            end
            if (acc) mq.push_back({in_rest, in_note, in_beats});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [11:0] got, exp;
            got = {note, hush, busy, done, level, in_ready};
            exp = {m_note, m_hush, m_busy, m_done, 4'(mq.size()), (mq.size() < DEPTH)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t got note/hush/busy/done/level/rdy=%h required=%h",
                         $time, got, exp);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic r, input logic [3:0] n, input logic [3:0] b);
        in_valid = 1'b1; in_rest = r; in_note = n; in_beats = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks n consecutive cycles of the given output pattern, reporting bad-cycle count.
    task automatic seg(input string name, input logic [3:0] n_exp, input logic h_exp, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (note !== n_exp || hush !== h_exp || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        chk(name, bad, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rest = 1'b0; in_note = 4'd0; in_beats = 4'd0;
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("rst_note",  note, 0);
        chk("rst_hush",  hush, 1);
        chk("rst_level", level, 0);
        chk("rst_ready", in_ready, 1);
        #1 rst_n = 1'b1;
        @(negedge clk);

`ifdef NOTE_SEQ_GAP_EN
        // Gap between entries
        push(0, 4'h3, 4'd1);
        push(0, 4'h4, 4'd1);
        pulse_start();
        seg("gap_note3", 4'h3, 1'b0, 4);
        seg("gap_hush",  4'h3, 1'b1, 2);
        seg("gap_note4", 4'h4, 1'b0, 4);
        chk("gap_done", done, 1);
        @(negedge clk);
        chk("gap_done_clear", done, 0);
`else
        // Basic melody including a rest and a 16-beat (encoded 0) entry
        push(0, 4'h2, 4'd1);
        push(1, 4'h5, 4'd2);
        push(0, 4'hF, 4'd0);
        chk("mel_level3", level, 3);
        pulse_start();
        seg("mel_note2", 4'h2, 1'b0, 4);
        seg("mel_rest",  4'h5, 1'b1, 8);
        seg("mel_noteF", 4'hF, 1'b0, 64);
        chk("mel_done", done, 1);
        chk("mel_end_hush", hush, 1);
        chk("mel_end_busy", busy, 0);
        @(negedge clk);
        chk("mel_done_clear", done, 0);
`endif

        // FIFO full, held 9th entry, accepted after a pop; then play through (pointer wrap)
        do_reset();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_rest = 1'b0; in_note = 4'(k); in_beats = 4'd1;
            @(negedge clk);
        end
        chk("full_level", level, 8);
        chk("full_ready", in_ready, 0);
        in_note = 4'd9;
        @(negedge clk);
        chk("full_held", level, 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("full_pop_level", level, 7);
        chk("full_pop_ready", in_ready, 1);
        chk("full_first_note", note, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_refill", level, 8);
        repeat (45) @(negedge clk);
        chk("full_drained_busy", busy, 0);

        // Stop mid-note keeps the queue; restart plays the next entry
        do_reset();
        push(0, 4'h1, 4'd4);
        push(0, 4'h2, 4'd4);
        push(0, 4'h3, 4'd4);
        pulse_start();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_hush",  hush, 1);
        chk("stop_busy",  busy, 0);
        chk("stop_done",  done, 0);
        chk("stop_level", level, 2);
        repeat (3) @(negedge clk);
        pulse_start();
        chk("restart_note", note, 2);
        chk("restart_hush", hush, 0);
        chk("restart_busy", busy, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Start with empty FIFO is ignored; stop beats start
        do_reset();
        pulse_start();
        begin
            int bad = 0;
            for (int i = 0; i < 5; i++) begin
                if (busy !== 1'b0 || hush !== 1'b1 || done !== 1'b0) bad++;
                @(negedge clk);
            end
            chk("empty_start_idle", bad, 0);
        end
        push(0, 4'h7, 4'd1);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("stop_over_start_busy",  busy, 0);
        chk("stop_over_start_level", level, 1);

        // Asynchronous reset in the middle of playback
        do_reset();
        push(0, 4'hA, 4'd2);
        push(0, 4'hB, 4'd2);
        pulse_start();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_note",  note, 0);
        chk("arst_hush",  hush, 1);
        chk("arst_level", level, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_busy",  busy, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: melody FIFO entries, power of two.
REQ-002 Parameter BEAT_CYCLES, default 25000000: clk cycles per beat.
REQ-003 Parameter GAP_CYCLES, default 1000000: articulation gap length in cycles; used only with REQ-031.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  melody entry offered.
REQ-007 in_ready  out  1  FIFO can accept an entry.
REQ-008 in_rest  in  1  entry is a rest (silent).
REQ-009 in_note  in  4  tone index 0..15 for the downstream tone generator.
REQ-010 in_beats  in  4  duration in beats; 0 encodes 16.
REQ-011 start  in  1  begin playback (level-sampled).
REQ-012 stop  in  1  abort playback (level-sampled).
REQ-013 note  out  4  registered tone index to the tone generator.
REQ-014 hush  out  1  registered mute to the tone generator; 1 = silent.
REQ-015 busy  out  1  high in PLAY or GAP.
REQ-016 done  out  1  one-cycle pulse at natural end of melody.
REQ-017 level  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-018 FIFO SHALL accept an entry {in_rest,in_note,in_beats} on any edge with in_valid && in_ready; in_ready SHALL be (level < DEPTH).
REQ-019 Pop and push in the same cycle SHALL leave level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-020 States SHALL be IDLE, PLAY, GAP; busy = (state != IDLE).
REQ-021 IDLE: hush=1, note holds its last value.
REQ-022 IDLE with start=1, stop=0, level>0: on that edge the head entry is popped, note<=entry note, hush<=entry rest, beat counters cleared, state<=PLAY.
REQ-023 IDLE with start=1 and level=0: ignored; stays IDLE, no done.
REQ-024 PLAY: a prescaler counts 0..BEAT_CYCLES-1; each wrap decrements the remaining-beat count; an entry lasts exactly beats*BEAT_CYCLES cycles from its load edge.
REQ-025 End of entry with level>0 (gap disabled): the next entry loads on the same edge; no silent cycle between entries.
REQ-026 End of entry with level=0: state<=IDLE, hush<=1, done pulses for one cycle.
REQ-027 stop=1 in any state: state<=IDLE and hush<=1 on that edge; FIFO contents retained; no done; stop overrides start.
REQ-028 start in PLAY or GAP SHALL be ignored; FIFO writes remain allowed during playback.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, note=0, hush=1, busy=0, done=0, level=0 (FIFO emptied), pointers and counters 0, including mid-PLAY.
REQ-030 After rst_n deasserts, the first action SHALL occur no earlier than the first posedge clk.

Configuration
REQ-031 Macro NOTE_SEQ_GAP_EN defined: at each entry end with level>0, enter GAP with hush=1 for exactly GAP_CYCLES cycles, then load the next entry (REQ-022 load actions) and return to PLAY. If level=0 at the end of GAP, go IDLE with done. Entry end with level=0 goes straight to IDLE with done, no GAP.
REQ-032 NOTE_SEQ_GAP_EN undefined: GAP state and gap counter SHALL not be synthesized; REQ-025 applies.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2, DEPTH=8 unless noted)
REQ-033 Push {0,2,1},{1,5,2},{0,F,0}; pulse start -> note=2 hush=0 for 4 cycles; hush=1 for 8 cycles; note=F hush=0 for 64 cycles; then hush=1 and done high exactly 1 cycle.
REQ-034 Push 9 entries back-to-back -> in_ready=0 after 8th accept, level=8; 9th held; after start, level=7 and 9th accepted next edge, level=8.
REQ-035 stop at cycle 2 of a 4-beat note with 3 entries queued -> hush=1 next edge, busy=0, no done, level=2; start again -> plays next queued entry.
REQ-036 start with empty FIFO -> state IDLE, hush=1, busy=0, done never asserted.
REQ-037 rst_n low mid-PLAY -> note=0, hush=1, level=0, in_ready=1 without a clock edge.
REQ-038 NOTE_SEQ_GAP_EN defined, push {0,3,1},{0,4,1}, start -> hush=0 note=3 4 cycles; hush=1 2 cycles; hush=0 note=4 4 cycles; done 1 cycle.
